// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter. A WIDTH-bit pattern is loaded through a
// valid/ready handshake and shifted out one bit per clock, MSB-first or
// LSB-first, repeated a programmable number of times. The stream feeds the
// x input of the overlapping sequence detectors.
//
// Handshake: a load is accepted on a rising edge where load_valid and
// load_ready are both high. load_ready is high exactly when the FSM is idle;
// load_valid while busy is ignored, and the producer may drop or change
// load_valid at any time without consequence.
//
// Configuration macro:
//   SEQ_PATTERN_TX_GAP_EN  when defined, one x_valid=0 cycle (GAP state) is
//                          inserted between consecutive copies. When not
//                          defined, copies are strictly back-to-back.
//
// Parameters:
//   WIDTH       pattern length in bits (>= 2)
//   CNT_W       width of the repeat count
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   load_valid  load request
//   load_ready  high when a load can be accepted (FSM in IDLE)
//   pattern     bits to send, captured on accept
//   lsb_first   0: pattern[WIDTH-1] first, 1: pattern[0] first
//   repeat_cnt  number of copies (0 treated as 1), captured on accept
//   abort       synchronous cancel while busy
//   x           serial data bit (registered, 0 when x_valid=0)
//   x_valid     x carries a pattern bit this cycle
//   busy        high in SEND or GAP
//   done        one-cycle pulse after the last bit of the last copy
//   dbg_state   current FSM state (0 IDLE, 1 SEND, 2 GAP)
// ---------------------------------------------------------------------------
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic             lsb_first,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef SEQ_PATTERN_TX_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
`endif

    // Registered state and captured transfer parameters
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pattern;
    logic             r_lsb_first;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_copy;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_x;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;

    // Combinational next values
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_last_copy;
    logic [IDX_W-1:0] w_bit_idx_nxt;
    logic [CNT_W-1:0] w_copy_nxt;
    logic [CNT_W-1:0] w_target_in;
    logic [WIDTH-1:0] w_sel_pattern;
    logic             w_sel_lsb;
    logic [IDX_W-1:0] w_rev_idx;
    logic             w_x_nxt;
    logic             w_x_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    assign w_accept    = load_valid && (r_state == ST_IDLE);
    assign w_last_bit  = (r_bit_idx == LAST_IDX);
    assign w_last_copy = (r_copy == (r_target - 1'b1));
    assign w_target_in = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic (abort wins over bit advance)
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_bit) begin
                    if (w_last_copy) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
`ifdef SEQ_PATTERN_TX_GAP_EN
                        w_state_nxt = ST_GAP;
`else
                        w_state_nxt = ST_SEND;
`endif
                    end
                end
            end
`ifdef SEQ_PATTERN_TX_GAP_EN
            ST_GAP: begin
                w_state_nxt = abort ? ST_IDLE : ST_SEND;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit index and copy counter next values. The copy count only advances
    // while copies remain, so it never exceeds target-1 and cannot wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        w_bit_idx_nxt = r_bit_idx;
        w_copy_nxt    = r_copy;
        if (w_accept) begin
            w_bit_idx_nxt = '0;
            w_copy_nxt    = '0;
        end else if ((r_state == ST_SEND) && !abort) begin
            if (w_last_bit) begin
                w_bit_idx_nxt = '0;
                if (!w_last_copy) begin
                    w_copy_nxt = r_copy + 1'b1;
                end
            end else begin
                w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs. On accept the
    // pattern registers are loading in the same edge, so the first bit is
    // taken straight from the inputs.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel_pattern = w_accept ? pattern : r_pattern;
        w_sel_lsb     = w_accept ? lsb_first : r_lsb_first;
        w_rev_idx     = LAST_IDX - w_bit_idx_nxt;
        w_x_valid_nxt = (w_state_nxt == ST_SEND);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_x_nxt       = 1'b0;
        if (w_x_valid_nxt) begin
            w_x_nxt = w_sel_lsb ? w_sel_pattern[w_bit_idx_nxt]
                                : w_sel_pattern[w_rev_idx];
        end
        w_done_nxt    = (r_state == ST_SEND) && !abort && w_last_bit && w_last_copy;
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern   <= '0;
            r_lsb_first <= 1'b0;
            r_target    <= CNT_W'(1);
            r_copy      <= '0;
            r_bit_idx   <= '0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pattern   <= pattern;
                r_lsb_first <= lsb_first;
                r_target    <= w_target_in;
            end
            r_copy    <= w_copy_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Directed bench for seq_pattern_tx (WIDTH=4, CNT_W=8). Expected streams are
// hand-written per test as a per-cycle valid mask and data word, queued in
// exp_q and compared cycle by cycle. Build with SEQ_PATTERN_TX_GAP_EN to
// select the gapped expectations.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic             lsb_first;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {valid, x} expected for each stream cycle
  logic [1:0] exp_q[$];

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .lsb_first  (lsb_first),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Load one transfer and check every stream cycle plus the done cycle.
  // ev/ex hold the expected valid mask and data, first cycle in bit n-1.
  // poke_at >= 0 pulses a spurious load with different fields in that cycle.
  task automatic run_xfer(input string tag, input logic [WIDTH-1:0] pat,
                          input logic lsb, input logic [CNT_W-1:0] rpt,
                          input logic [31:0] ev, input logic [31:0] ex,
                          input int n, input int poke_at);
    logic [1:0] e;
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({ev[i], ex[i]});
    check({tag, "_ready_pre"}, load_ready, 1);
    load_valid = 1'b1;
    pattern    = pat;
    lsb_first  = lsb;
    repeat_cnt = rpt;
    step();
    load_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      load_valid = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s_v%0d", tag, c), x_valid, e[1]);
      check($sformatf("%s_x%0d", tag, c), x, e[0]);
      check($sformatf("%s_busy%0d", tag, c), busy, 1);
      check($sformatf("%s_done%0d", tag, c), done, 0);
      if (c == poke_at) begin
        check({tag, "_ready_busy"}, load_ready, 0);
        load_valid = 1'b1;
        pattern    = ~pat;
        lsb_first  = ~lsb;
        repeat_cnt = rpt + 8'd3;
      end
      step();
    end
    load_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_ready_post"}, load_ready, 1);
    check({tag, "_v_post"}, x_valid, 0);
    check({tag, "_x_post"}, x, 0);
    check({tag, "_busy_post"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    pattern    = '0;
    lsb_first  = 1'b0;
    repeat_cnt = '0;
    abort      = 1'b0;
    #1;
    check("rst_ready", load_ready, 1);
    check("rst_valid", x_valid, 0);
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);

    // MSB-first single copy: 1,0,1,0
    run_xfer("msb", 4'b1010, 1'b0, 8'd1, 32'hF, 32'b1010, 4, -1);
    idle_cycles(2);

    // LSB-first 1101: 1,0,1,1
    run_xfer("lsb", 4'b1101, 1'b1, 8'd1, 32'hF, 32'b1011, 4, -1);
    idle_cycles(2);

    // Three copies of 1010
`ifdef SEQ_PATTERN_TX_GAP_EN
    run_xfer("rep3", 4'b1010, 1'b0, 8'd3, 32'b11110111101111,
             32'b10100101001010, 14, -1);
`else
    run_xfer("rep3", 4'b1010, 1'b0, 8'd3, 32'hFFF, 32'b101010101010, 12, -1);
`endif
    idle_cycles(2);

    // repeat_cnt=0 sends exactly one copy
    run_xfer("rpt0", 4'b0110, 1'b0, 8'd0, 32'hF, 32'b0110, 4, -1);
    idle_cycles(2);

    // Spurious load during bit 2 is ignored
    run_xfer("poke", 4'b1100, 1'b0, 8'd1, 32'hF, 32'b1100, 4, 2);
    idle_cycles(2);

    // Back-to-back: second load presented in the done cycle of the first
    run_xfer("b2b_a", 4'b1001, 1'b0, 8'd1, 32'hF, 32'b1001, 4, -1);
    run_xfer("b2b_b", 4'b0111, 1'b1, 8'd1, 32'hF, 32'b1110, 4, -1);
    idle_cycles(2);

    // Abort during bit 2 of 4
    load_valid = 1'b1;
    pattern    = 4'b1010;
    lsb_first  = 1'b0;
    repeat_cnt = 8'd1;
    step();
    load_valid = 1'b0;
    check("abort_b0", x, 1);
    step();
    check("abort_b1", x, 0);
    step();
    check("abort_b2", x, 1);
    check("abort_b2_v", x_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", x_valid, 0);
    check("abort_done", done, 0);
    check("abort_ready", load_ready, 1);
    check("abort_busy", busy, 0);
    step();
    check("abort_done2", done, 0);
    check("abort_valid2", x_valid, 0);
    idle_cycles(2);

    // Asynchronous reset mid-stream
    load_valid = 1'b1;
    pattern    = 4'b1111;
    lsb_first  = 1'b0;
    repeat_cnt = 8'd3;
    step();
    load_valid = 1'b0;
    step();
    check("arst_pre_valid", x_valid, 1);
    check("arst_pre_x", x, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", x_valid, 0);
    check("arst_x", x, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", load_ready, 1);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("arst_after_done%0d", i), done, 0);
      check($sformatf("arst_after_valid%0d", i), x_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
